// File: rtl/fetch_buffered.sv
// fetch_buffered: fetch stage with a DEPTH-entry prefetch FIFO.
//
// Runs a fetch PC ahead of decode with at most one outstanding instruction-memory
// request. Returned words are queued with their PCs and presented to decode one per
// cycle through a registered output stage. Handles stall, flush and jump redirects,
// and drops a response that was already in flight when a jump arrived.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_stall                decode cannot accept; output register holds
//   i_flush                kill the instruction in the output register
//   i_jump, i_jump_addr    redirect fetch (address bits [1:0] ignored)
//   i_inst_data/ack        memory response for the pending request
//   or_inst_req/_addr      pending memory request
//   or_inst_data, or_pc    instruction and its PC presented to decode
//   or_valid               output register holds a live instruction
//   or_fifo_count          prefetch FIFO occupancy
module fetch_buffered #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_jump,
    input  logic [XLEN-1:0]            i_jump_addr,
    input  logic [31:0]                i_inst_data,
    input  logic                       i_inst_ack,
    output logic                       or_inst_req,
    output logic [XLEN-1:0]            or_inst_req_addr,
    output logic [31:0]                or_inst_data,
    output logic [XLEN-1:0]            or_pc,
    output logic                       or_valid,
    output logic [$clog2(DEPTH+1)-1:0] or_fifo_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              discard_q, discard_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              out_valid_q, out_valid_d;

    logic [XLEN-1:0]   fifo_pc_q   [DEPTH];
    logic [31:0]       fifo_data_q [DEPTH];

    logic              ack;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   jump_tgt;

    always_comb begin
        // An ack only counts while a request is actually pending.
        ack      = (state_q == StWait) && i_inst_ack;
        jump_tgt = i_jump_addr & ~XLEN'(3);
        push     = ack && !discard_q && !i_jump;
        pop      = !i_jump && !i_flush && !i_stall && (count_q != '0);
    end

    // Fetch PC, FIFO pointers/occupancy and the stale-response flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (i_jump) begin
            fetch_pc_d = jump_tgt;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            count_d  = count_q + CntW'(push) - CntW'(pop);
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
        end
        if (ack) begin
            discard_d = 1'b0;
        end else if (i_jump && (state_q == StWait)) begin
            // Old request stays on the bus; its response must be dropped.
            discard_d = 1'b1;
        end
    end

    // Request FSM. A request is only raised while a FIFO slot is free for it, and
    // only one is ever outstanding, so a push can never overflow the FIFO.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            StIdle: begin
                if (i_jump || (32'(count_q) < DEPTH)) begin
                    state_d    = StWait;
                    req_addr_d = fetch_pc_d;
                end
            end
            StWait: begin
                if (ack) begin
                    if (!discard_q && (32'(count_d) < DEPTH)) begin
                        // Back-to-back: next address (or jump target) right away.
                        req_addr_d = fetch_pc_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: jump/flush beat stall, stall beats pop.
    always_comb begin
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        if (i_jump || i_flush) begin
            out_data_d  = NOP_INST;
            out_valid_d = 1'b0;
        end else if (!i_stall) begin
            if (pop) begin
                out_data_d  = fifo_data_q[rd_ptr_q];
                out_pc_d    = fifo_pc_q[rd_ptr_q];
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            fetch_pc_q  <= RESET_PC;
            discard_q   <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= NOP_INST;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_addr_q;
            fifo_data_q[wr_ptr_q] <= i_inst_data;
        end
    end

    assign or_inst_req      = (state_q == StWait);
    assign or_inst_req_addr = req_addr_q;
    assign or_inst_data     = out_data_q;
    assign or_pc            = out_pc_q;
    assign or_valid         = out_valid_q;
    assign or_fifo_count    = count_q;

endmodule

// File: tb/tb_fetch_buffered.sv
// Bench for fetch_buffered: random and directed stimulus against a queue-based model
// of the fetch stream; expected output-register states go through a scoreboard queue.
module tb_fetch_buffered;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_flush, i_jump, i_inst_ack;
    logic [31:0] i_jump_addr, i_inst_data;
    logic        or_inst_req, or_valid;
    logic [31:0] or_inst_req_addr, or_inst_data, or_pc;
    logic [2:0]  or_fifo_count;

    fetch_buffered #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .i_jump           (i_jump),
        .i_jump_addr      (i_jump_addr),
        .i_inst_data      (i_inst_data),
        .i_inst_ack       (i_inst_ack),
        .or_inst_req      (or_inst_req),
        .or_inst_req_addr (or_inst_req_addr),
        .or_inst_data     (or_inst_data),
        .or_pc            (or_pc),
        .or_valid         (or_valid),
        .or_fifo_count    (or_fifo_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en   = 1'b0;
    exp_t        exp_q[$];

    // Reference model state
    word_t       mq[$];
    logic [31:0] m_fetch_pc;
    bit          m_stale;
    logic        m_valid;
    logic [31:0] m_pc, m_data;
    int          wait_cnt;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_fetch_pc = RESET_PC;
        m_stale    = 1'b0;
        m_valid    = 1'b0;
        m_pc       = '0;
        m_data     = NOP_INST;
        wait_cnt   = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", or_inst_req, 0);
        chk("rst_req_addr", or_inst_req_addr, 0);
        chk("rst_data", or_inst_data, NOP_INST);
        chk("rst_pc", or_pc, 0);
        chk("rst_valid", or_valid, 0);
        chk("rst_count", or_fifo_count, 0);
    endtask

    // Called just after a falling edge: drive inputs for the next rising edge,
    // advance the model across that edge, queue the expected result, wait a cycle.
    // mode: 0 no ack, 1 ack every cycle, 2 ack on third request cycle, 3 random ack.
    task automatic step(input logic st, input logic fl, input logic jp,
                        input logic [31:0] ja, input int mode);
        logic  req, ack;
        exp_t  e;
        word_t w;
        req = or_inst_req;
        ack = 1'b0;
        if (req) begin
            if (mode == 1)      ack = 1'b1;
            else if (mode == 2) ack = (wait_cnt >= 2);
            else if (mode == 3) ack = ($urandom_range(0, 9) < 6);
        end else begin
            ack = 1'($urandom_range(0, 1));  // must be ignored
        end
        if (req && !ack) wait_cnt++;
        else             wait_cnt = 0;

        i_stall     = st;
        i_flush     = fl;
        i_jump      = jp;
        i_jump_addr = ja;
        i_inst_ack  = ack;
        i_inst_data = (req && ack) ? inst_of(or_inst_req_addr) : $urandom();

        if (req && !m_stale) chk("req_addr", or_inst_req_addr, m_fetch_pc);

        if (jp || fl) begin
            m_valid = 1'b0;
            m_data  = NOP_INST;
        end else if (!st) begin
            if (mq.size() > 0) begin
                w       = mq.pop_front();
                m_valid = 1'b1;
                m_pc    = w.pc;
                m_data  = w.data;
            end else begin
                m_valid = 1'b0;
            end
        end

        if (req && ack) begin
            if (m_stale || jp) begin
                m_stale = 1'b0;
            end else begin
                chk("slot_free", mq.size() < DEPTH, 1);
                w.pc   = m_fetch_pc;
                w.data = inst_of(m_fetch_pc);
                mq.push_back(w);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        if (jp) begin
            mq.delete();
            m_fetch_pc = ja & ~32'd3;
            if (req && !ack) m_stale = 1'b1;
        end

        e.v    = m_valid;
        e.pc   = m_pc;
        e.data = m_data;
        e.cnt  = mq.size();
        exp_q.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic rand_step();
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 24) == 0), $urandom() & 32'h0000_0FFF, 3);
    endtask

    // Monitor: compares the DUT output register after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", or_valid, e.v);
                chk("out_pc", or_pc, e.pc);
                chk("out_data", or_inst_data, e.data);
                chk("fifo_count", or_fifo_count, e.cnt);
            end
        end
    end

    initial begin
        i_rst_n = 1'b1;
        i_stall = 1'b0; i_flush = 1'b0; i_jump = 1'b0; i_inst_ack = 1'b0;
        i_jump_addr = '0; i_inst_data = '0;
        model_reset();
        #2 i_rst_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Streaming with single-cycle memory
        step(0, 0, 0, 0, 1);
        chk("first_req", or_inst_req, 1);
        chk("first_req_addr", or_inst_req_addr, RESET_PC);
        repeat (29) step(0, 0, 0, 0, 1);

        // Long stall: FIFO fills, request drops, then drains in order
        repeat (10) step(1, 0, 0, 0, 1);
        chk("stall_req_off", or_inst_req, 0);
        chk("stall_full", or_fifo_count, DEPTH);
        repeat (12) step(0, 0, 0, 0, 1);

        // Three-cycle memory latency
        repeat (20) step(0, 0, 0, 0, 2);

        // Jump while a request is pending; its response arrives two cycles later
        for (int i = 0; i < 10 && !(or_inst_req && wait_cnt == 0); i++) step(0, 0, 0, 0, 2);
        chk("jump_setup", or_inst_req && wait_cnt == 0, 1);
        step(0, 0, 1, 32'h100, 2);
        repeat (15) step(0, 0, 0, 0, 2);

        // Flush with three buffered entries
        for (int i = 0; i < 10 && mq.size() < 3; i++) step(1, 0, 0, 0, 1);
        chk("flush_setup", mq.size(), 3);
        step(0, 1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 1);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFF8, 1);
        repeat (10) step(0, 0, 0, 0, 1);

        repeat (400) rand_step();

        // Asynchronous reset mid-request with two buffered entries
        step(0, 0, 1, 32'h40, 1);
        for (int i = 0; i < 20 && mq.size() < 2; i++) step(1, 0, 0, 0, 1);
        chk("rst_setup", mq.size(), 2);
        step(1, 0, 0, 0, 0);
        mon_en = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        step(0, 0, 0, 0, 1);
        chk("restart_req", or_inst_req, 1);
        chk("restart_addr", or_inst_req_addr, RESET_PC);
        repeat (60) rand_step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
